// File: rtl/pwm_up_pkg.sv
// Shared definitions for the uplink status-frame transmitter: frame layout,
// frame type code and the serialiser FSM encoding.
package pwm_up_pkg;

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned STATE_W = 8;
  localparam int unsigned SEQ_W   = 7;

  localparam int unsigned TYPE_LSB  = 20;
  localparam int unsigned FLAG_LSB  = 15;
  localparam int unsigned STATE_LSB = 7;
  localparam int unsigned SEQ_LSB   = 0;

  localparam logic [3:0] FRAME_TYPE = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } tx_state_e;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [3:0]         ftype;
    logic [FLAG_W-1:0]  flags;
    logic [STATE_W-1:0] unit_state;
    logic [SEQ_W-1:0]   seq;
  } frame_t;

  // Odd parity: F plus P always carries an odd number of ones.
  function automatic logic odd_parity(input frame_t f);
    return ~^f;
  endfunction

endpackage

// File: rtl/man_tx.sv
// Manchester serialiser: SYNC marker, 24 data bits MSB first, parity bit,
// then an idle gap. Line level and status flags leave from registers.
module man_tx
  import pwm_up_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter int unsigned GAP_BITS = 4,
  parameter int unsigned TX_INV   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [FRAME_W:0] word_i,
  output logic             txd_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int unsigned HALF     = DIV / 2;
  localparam int unsigned SYNC_LEN = 3 * DIV;
  localparam int unsigned GAP_LEN  = GAP_BITS * DIV;
  localparam int unsigned CNT_MAX  = (SYNC_LEN > GAP_LEN) ? SYNC_LEN : GAP_LEN;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX);
  localparam int unsigned BIT_W    = $clog2(FRAME_W);
  localparam int unsigned SH_W     = FRAME_W + 1;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [SH_W-1:0]  sh_q, sh_d;
  logic             enc_d, busy_d, done_d;
  logic             txd_q, busy_q, done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Phase sequencing; the shift register presents the current bit at its MSB.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (load_i) begin
          state_d = ST_SYNC;
          bit_d   = '0;
          sh_d    = word_i;
        end
      end
      ST_SYNC: begin
        if (cnt_q == CNT_W'(SYNC_LEN - 1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {sh_q[SH_W-2:0], 1'b0};
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d = ST_PAR;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Levels are computed for the upcoming cycle so the registers show them on time.
  always_comb begin
    enc_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = 1'b0;
    case (state_d)
      ST_SYNC:         enc_d = (cnt_d < CNT_W'(SYNC_LEN / 2));
      ST_DATA, ST_PAR: enc_d = (cnt_d < CNT_W'(HALF)) ? sh_d[SH_W-1] : ~sh_d[SH_W-1];
      ST_GAP:          done_d = (cnt_d == CNT_W'(GAP_LEN - 1));
      default:         enc_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      txd_q  <= 1'(TX_INV);
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      txd_q  <= (TX_INV != 0) ? ~enc_d : enc_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign txd_o        = txd_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: rtl/pwm_up.sv
// Uplink status transmitter: sticky fault capture, periodic and fault-driven
// frame triggering, sequence numbering; serialisation is done by man_tx.
module pwm_up
  import pwm_up_pkg::*;
#(
  parameter int unsigned DIV        = 4,
  parameter int unsigned PERIOD_CLK = 8000,
  parameter int unsigned GAP_BITS   = 4,
  parameter int unsigned TX_INV     = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic               fault,
  input  logic               fault1,
  input  logic               fault2,
  input  logic               fault3,
  input  logic               fault4,
  input  logic [STATE_W-1:0] state_in,
  output logic               txd,
  output logic               busy,
  output logic               frame_done,
  output logic [SEQ_W-1:0]   seq
);

  localparam int unsigned PER_W = $clog2(PERIOD_CLK);

  logic [FLAG_W-1:0] flt_in, sticky_q, sticky_d, prev_q, rise_q;
  logic [PER_W-1:0]  per_q, per_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              pend_q, pend_d;
  logic              tick, trig, load, tx_busy;
  frame_t            frame;
  logic [FRAME_W:0]  word;

  assign flt_in = {fault, fault1, fault2, fault3, fault4};
  assign tick   = en && (per_q == PER_W'(PERIOD_CLK - 1));
  assign trig   = tick || (|rise_q);
  assign load   = !tx_busy && en && (pend_q || trig);

  // On the load edge the sticky flags go into the frame and restart from the live inputs.
  always_comb begin
    per_d            = '0;
    if (en && !tick) per_d = per_q + PER_W'(1);
    seq_d            = load ? (seq_q + SEQ_W'(1)) : seq_q;
    pend_d           = (pend_q || trig) && !load;
    sticky_d         = load ? flt_in : (sticky_q | flt_in);
    frame.ftype      = FRAME_TYPE;
    frame.flags      = sticky_q;
    frame.unit_state = state_in;
    frame.seq        = seq_q + SEQ_W'(1);
  end

  assign word = {frame, odd_parity(frame)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      per_q    <= '0;
      seq_q    <= '0;
      pend_q   <= 1'b0;
      sticky_q <= '0;
      prev_q   <= '0;
      rise_q   <= '0;
    end else begin
      per_q    <= per_d;
      seq_q    <= seq_d;
      pend_q   <= pend_d;
      sticky_q <= sticky_d;
      prev_q   <= flt_in;
      rise_q   <= flt_in & ~prev_q;
    end
  end

  man_tx #(
    .DIV      (DIV),
    .GAP_BITS (GAP_BITS),
    .TX_INV   (TX_INV)
  ) u_man_tx (
    .clk          (clk),
    .rstn         (rstn),
    .load_i       (load),
    .word_i       (word),
    .txd_o        (txd),
    .busy_o       (tx_busy),
    .frame_done_o (frame_done)
  );

  assign busy = tx_busy;
  assign seq  = seq_q;

endmodule
